// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: hazard FSM state encoding and register-index width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decode_pkg;

  localparam int REG_W_DEF = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_MC_BUSY  = 2'd2;
  localparam state_t ST_REDIRECT = 2'd3;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: flags an ID instruction that reads the destination of a load in EX.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result is consumed by the hazard sequencer.
module hazard_detect
  import decode_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  output logic             load_use
);

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  always_comb begin
    load_use = ex_is_load && (ex_rd != '0) &&
               ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB pipeline registers.
// Latency: stall/flush are combinational from state+inputs; mc_timeout and stall_cycles are registered.
// Backpressure: holds the front of the pipe during memory waits, multi-cycle ops and load-use bubbles.
module hazard_ctrl
  import decode_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int REDIR_CYC = 2,
  parameter int MC_MAX    = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             stall_idex,
  output logic             flush_idex,
  output logic             stall_exmem,
  output logic             flush_exmem,
  output logic             stall_memwb,
  output logic             flush_memwb,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int RCW = (REDIR_CYC > 1) ? $clog2(REDIR_CYC + 1) : 1;
  localparam int MCW = (MC_MAX > 1) ? $clog2(MC_MAX) : 1;

  state_t         state, state_nx;
  logic           pend_redir, pend_redir_nx;
  logic           redir_first, redir_first_nx;
  logic [RCW-1:0] redir_cnt, redir_cnt_nx;
  logic [MCW-1:0] mc_cnt, mc_cnt_nx;
  logic           mc_timeout_nx;
  logic           load_use;
  logic           mem_stall;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use1    (id_use1),
    .id_use2    (id_use2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .load_use   (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  // State register plus the redirect/multi-cycle bookkeeping that travels with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      pend_redir  <= 1'b0;
      redir_first <= 1'b0;
      redir_cnt   <= '0;
      mc_cnt      <= '0;
      mc_timeout  <= 1'b0;
    end else begin
      state       <= state_nx;
      pend_redir  <= pend_redir_nx;
      redir_first <= redir_first_nx;
      redir_cnt   <= redir_cnt_nx;
      mc_cnt      <= mc_cnt_nx;
      mc_timeout  <= mc_timeout_nx;
    end
  end

  // Next-state: RUN checks memory wait, multi-cycle start, branch in that priority order.
  always_comb begin
    state_nx       = state;
    pend_redir_nx  = pend_redir;
    redir_first_nx = 1'b0;
    redir_cnt_nx   = redir_cnt;
    mc_cnt_nx      = mc_cnt;
    mc_timeout_nx  = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          // A branch resolving under a memory wait is replayed once memory completes.
          state_nx      = ST_MEM_WAIT;
          pend_redir_nx = ex_br_taken;
        end else if (ex_mc_start) begin
          state_nx  = ST_MC_BUSY;
          mc_cnt_nx = '0;
        end else if (ex_br_taken && (REDIR_CYC > 1)) begin
          state_nx     = ST_REDIRECT;
          redir_cnt_nx = RCW'(REDIR_CYC - 1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          pend_redir_nx = 1'b0;
          if (pend_redir) begin
            state_nx       = ST_REDIRECT;
            redir_cnt_nx   = RCW'(REDIR_CYC);
            redir_first_nx = 1'b1;
          end else begin
            state_nx = ST_RUN;
          end
        end
      end
      ST_MC_BUSY: begin
        mc_cnt_nx = mc_cnt + MCW'(1);
        if (ex_mc_done) begin
          state_nx = ST_RUN;
        end else if (mc_cnt == MCW'(MC_MAX - 1)) begin
          state_nx      = ST_RUN;
          mc_timeout_nx = 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (ex_br_taken) begin
          redir_cnt_nx = RCW'(REDIR_CYC);
        end else begin
          redir_cnt_nx = redir_cnt - RCW'(1);
          if (redir_cnt == RCW'(1)) begin
            state_nx = ST_RUN;
          end
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  // Outputs: stall and flush never target the same boundary; everything is quiet during reset.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    stall_idex  = 1'b0;
    flush_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_exmem = 1'b0;
    stall_memwb = 1'b0;
    flush_memwb = 1'b0;
    if (rst) begin
      case (state)
        ST_RUN: begin
          if (!mem_stall && !ex_mc_start) begin
            if (ex_br_taken) begin
              flush_ifid = 1'b1;
              flush_idex = 1'b1;
            end else if (load_use) begin
              stall_pc   = 1'b1;
              stall_ifid = 1'b1;
              flush_idex = 1'b1;
            end
          end
        end
        ST_MEM_WAIT: begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          stall_idex  = 1'b1;
          stall_exmem = 1'b1;
          flush_memwb = 1'b1;
        end
        ST_MC_BUSY: begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          stall_idex  = 1'b1;
          flush_exmem = 1'b1;
        end
        ST_REDIRECT: begin
          flush_ifid = 1'b1;
          flush_idex = redir_first;
        end
        default: ;
      endcase
    end
  end

  // Perf counter of PC-stall cycles, pinned at all-ones once full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall_pc && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int REG_W  = 5;
  localparam int CNT_W  = 7;
  localparam int SC_MAX = (1 << CNT_W) - 1;

  // Bit order: stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex,
  //            stall_exmem, flush_exmem, stall_memwb, flush_memwb
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110010000;
  localparam logic [8:0] MW   = 9'b110101001;
  localparam logic [8:0] MC   = 9'b110100100;
  localparam logic [8:0] BR   = 9'b001010000;
  localparam logic [8:0] RD   = 9'b001000000;

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use1, id_use2, ex_is_load, ex_br_taken;
  logic             ex_mc_start, ex_mc_done, mem_req, mem_ready;
  logic             stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex;
  logic             stall_exmem, flush_exmem, stall_memwb, flush_memwb;
  logic             mc_timeout;
  logic [CNT_W-1:0] stall_cycles;

  typedef struct {
    string       tag;
    logic [8:0]  sf;
    logic [31:0] sc;
    logic        mt;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   exp_sc = 0;

  logic [8:0] sf_vec;
  logic [3:0] overlap;
  assign sf_vec  = {stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex,
                    stall_exmem, flush_exmem, stall_memwb, flush_memwb};
  assign overlap = {stall_ifid & flush_ifid, stall_idex & flush_idex,
                    stall_exmem & flush_exmem, stall_memwb & flush_memwb};

  hazard_ctrl #(
    .REG_W(REG_W), .REDIR_CYC(2), .MC_MAX(64), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .stall_idex(stall_idex), .flush_idex(flush_idex),
    .stall_exmem(stall_exmem), .flush_exmem(flush_exmem),
    .stall_memwb(stall_memwb), .flush_memwb(flush_memwb),
    .mc_timeout(mc_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle of stimulus: the caller has set the inputs; queue what this cycle must show.
  task automatic drv(input logic [8:0] sf, input logic mt, input string tag);
    exp_t e;
    e.tag = tag;
    e.sf  = sf;
    e.sc  = exp_sc;
    e.mt  = mt;
    sb.push_back(e);
    if (!rst) exp_sc = 0;
    else if (sf[8] && exp_sc < SC_MAX) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use1 = 0; id_use2 = 0; ex_is_load = 0; ex_br_taken = 0;
    ex_mc_start = 0; ex_mc_done = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Mid-cycle comparison against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_sf"}, {23'b0, sf_vec}, {23'b0, e.sf});
      chk({e.tag, "_sc"}, {25'b0, stall_cycles}, e.sc);
      chk({e.tag, "_mt"}, {31'b0, mc_timeout}, {31'b0, e.mt});
      chk({e.tag, "_ovl"}, {28'b0, overlap}, 32'd0);
    end
  end

  initial begin
    clk = 0;
    idle();
    rst = 0;
    @(posedge clk);
    #1;

    // Reset cycles, with a load-use pattern present that must be ignored.
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 1;
    drv(NONE, 0, "rst0");
    drv(NONE, 0, "rst1");
    idle(); rst = 1;
    drv(NONE, 0, "idle");

    // Load-use via rs1, near miss, x0 destination, via rs2, rs2 not used.
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 1;
    drv(LU, 0, "lu_rs1");
    id_rs1 = 6;
    drv(NONE, 0, "lu_miss");
    ex_rd = 0; id_rs1 = 0;
    drv(NONE, 0, "lu_x0");
    ex_rd = 7; id_rs2 = 7; id_use2 = 1; id_use1 = 0;
    drv(LU, 0, "lu_rs2");
    id_use2 = 0;
    drv(NONE, 0, "lu_nouse");
    idle();

    // Memory wait: ready low for three cycles, then high.
    mem_req = 1; mem_ready = 0;
    drv(NONE, 0, "mw_enter");
    drv(MW, 0, "mw1");
    drv(MW, 0, "mw2");
    mem_ready = 1;
    drv(MW, 0, "mw3");
    idle();
    drv(NONE, 0, "mw_exit");

    // Taken branch: two IF/ID flushes, one ID/EX flush.
    ex_br_taken = 1;
    drv(BR, 0, "br");
    ex_br_taken = 0;
    drv(RD, 0, "br_redir");
    drv(NONE, 0, "br_done");

    // Second branch during REDIRECT restarts the flush window.
    ex_br_taken = 1;
    drv(BR, 0, "rr_br");
    drv(RD, 0, "rr_restart");
    ex_br_taken = 0;
    drv(RD, 0, "rr_r2");
    drv(RD, 0, "rr_r1");
    drv(NONE, 0, "rr_done");

    // Branch under a memory wait is replayed after the wait.
    mem_req = 1; mem_ready = 0; ex_br_taken = 1;
    drv(NONE, 0, "bm_enter");
    ex_br_taken = 0;
    drv(MW, 0, "bm_wait");
    mem_ready = 1;
    drv(MW, 0, "bm_ready");
    idle();
    drv(BR, 0, "bm_redir1");
    drv(RD, 0, "bm_redir2");
    drv(NONE, 0, "bm_done");

    // Multi-cycle timeout, twice, so the stall counter saturates.
    for (int rep = 0; rep < 2; rep++) begin
      ex_mc_start = 1;
      drv(NONE, 0, "mc_start");
      ex_mc_start = 0;
      for (int i = 0; i < 64; i++) drv(MC, 0, "mc_busy");
      drv(NONE, 1, "mc_to");
      drv(NONE, 0, "mc_after");
    end

    // Multi-cycle op finishing early: no timeout pulse.
    ex_mc_start = 1;
    drv(NONE, 0, "mcd_start");
    ex_mc_start = 0;
    drv(MC, 0, "mcd_b1");
    drv(MC, 0, "mcd_b2");
    ex_mc_done = 1;
    drv(MC, 0, "mcd_done");
    ex_mc_done = 0;
    drv(NONE, 0, "mcd_nopulse");

    // Done on the final allowed cycle wins over the timeout.
    ex_mc_start = 1;
    drv(NONE, 0, "mce_start");
    ex_mc_start = 0;
    for (int i = 0; i < 63; i++) drv(MC, 0, "mce_busy");
    ex_mc_done = 1;
    drv(MC, 0, "mce_last");
    ex_mc_done = 0;
    drv(NONE, 0, "mce_nopulse");

    // Reset in the middle of a multi-cycle op.
    ex_mc_start = 1;
    drv(NONE, 0, "rmc_start");
    ex_mc_start = 0;
    for (int i = 0; i < 5; i++) drv(MC, 0, "rmc_busy");
    rst = 0;
    drv(NONE, 0, "rmc_rst");
    rst = 1;
    drv(NONE, 0, "rmc_after");
    drv(NONE, 0, "rmc_idle");

    // Reset in the middle of a memory wait.
    mem_req = 1; mem_ready = 0;
    drv(NONE, 0, "rmw_enter");
    drv(MW, 0, "rmw_wait");
    rst = 0;
    drv(NONE, 0, "rmw_rst");
    rst = 1; idle();
    drv(NONE, 0, "rmw_after");

    @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
